pn_spread_tx: RTL
=================

// Module: pn_spread_tx
// PURPOSE
// Transmit-side counterpart of the PN receiver chain: BPSK direct-sequence spreader.
// Data bits arrive on a valid/ready handshake; each bit spans one full maximal-length PN period.
// Output is signed, amplitude-fixed baseband chips for the DAC / loopback into the receiver AGC.
// Each burst starts with unmodulated PN periods so the receiver can acquire code phase.
// PARAMETERS
// PN_DEG      10       LFSR degree; period = 2^PN_DEG-1 chips (1023)
// PN_TAPS     10'h009  feedback taps: fb = ^(lfsr & PN_TAPS) (x^10+x^3+1)
// PN_SEED     10'h3FF  LFSR load value (must be nonzero); marks chip 0
// CHIP_DIV    4        Clk cycles per chip (>=1)
// PRE_PER     2        unmodulated preamble periods per burst (>=1)
// AMPL        16'h4000 chip magnitude, positive, <= 16'h7FFF
// PORTS
// Clk       in   1   system clock
// Rst_n     in   1   asynchronous active-low reset
// En        in   1   block enable; low = synchronous abort to IDLE
// BitIn     in   1   data bit
// BitValid  in   1   BitIn valid
// BitReady  out  1   bit accepted when BitValid & BitReady at posedge
// Dout      out  16  signed chip sample (two's complement)
// DoutValid out  1   Dout carries a chip (PREAMBLE/DATA)
// Epoch     out  1   high during every cycle of chip 0 of each PN period
// Busy      out  1   state != IDLE
// BEHAVIOUR
// Reset: Dout=0, DoutValid=0, Epoch=0, Busy=0, BitReady=0; lfsr=PN_SEED, div cnt=0, state=IDLE.
// Chip timing: div cnt 0..CHIP_DIV-1; tick = (cnt==CHIP_DIV-1); lfsr steps on tick only.
// LFSR step: lfsr <= {^(lfsr & PN_TAPS), lfsr[PN_DEG-1:1]}; chip c = lfsr[0].
// Period end = tick while lfsr is on the last chip (next lfsr == PN_SEED).
// Symbol s = c ^ d (d = 0 in PREAMBLE, current bit in DATA); s=0 -> +AMPL, s=1 -> -AMPL.
// Dout/DoutValid/Epoch registered from next-state values; no combinational in->out path except BitReady.
// States:
//  IDLE: Dout=0, DoutValid=0, lfsr=PN_SEED, cnt=0. En & BitValid -> PREAMBLE, period ctr=0.
//        Bit NOT consumed in IDLE. Cycle after transition: chip 0 on Dout, Epoch=1 (1-cycle latency).
//  PREAMBLE: d=0. Period end increments ctr. Last period end:
//        BitValid -> accept, load d, -> DATA; else -> IDLE.
//  DATA: chips modulated by d. Each period end: BitValid -> accept, load d, stay;
//        else -> IDLE (next burst re-sends preamble).
// BitReady = En & tick & period end & (DATA | (PREAMBLE & last preamble period)); 1 cycle wide.
// Bit boundaries coincide exactly with PN period boundaries; bit changes on chip 0.
// En low any cycle (mid-chip, mid-period): next cycle IDLE, Dout=0, lfsr reseeded, no transfer.
// Rst_n low mid-burst: immediate return to reset values; held bit discarded.
// BitValid dropped mid-period: ignored; only sampled at BitReady.
// Arithmetic: -AMPL formed as ~AMPL+1 in 16 bits; AMPL=0 yields Dout=0 with DoutValid=1.
// TESTING
// T1 reset/idle: Rst_n low 5 cycles, BitValid=0 -> Dout=0, DoutValid=0, Busy=0, BitReady never 1.
// T2 PN check (CHIP_DIV=1, AMPL=16'h4000): BitValid=1 held -> first chip 16'hC000 with Epoch=1;
//    1023-chip preamble sequence matches golden LFSR model; Epoch repeats every 1023 cycles.
// T3 burst: PRE_PER=2, bits 1,0,1 then BitValid=0 -> BitReady pulses at cycles 2046, 3069, 4092
//    after start; DATA periods are inverted/true/inverted PN; then IDLE, Dout=0.
// T4 CHIP_DIV=4: each chip held exactly 4 cycles; Epoch high 4 cycles; period = 4092 cycles.
// T5 abort: En low at chip 500 of period 1 of DATA -> next cycle Dout=0, Busy=0;
//    re-enable with BitValid -> fresh preamble from chip 0, Epoch=1.
// T6 async reset mid-DATA: Rst_n low between edges -> outputs zero before next Clk edge;
//    after release, restart gives Dout=16'hC000 as first chip.

Source files
------------

// File: rtl/pn_spread_tx.sv
// BPSK direct-sequence spreader: one data bit per maximal-length PN period, each burst
// opening with unmodulated PN periods so the receiver can acquire code phase.
module pn_spread_tx #(
    parameter int unsigned       PN_DEG   = 32'd10,
    parameter logic [PN_DEG-1:0] PN_TAPS  = 10'h009,
    parameter logic [PN_DEG-1:0] PN_SEED  = 10'h3FF,
    parameter int unsigned       CHIP_DIV = 32'd4,
    parameter int unsigned       PRE_PER  = 32'd2,
    parameter logic [15:0]       AMPL     = 16'h4000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        En,
    input  logic        BitIn,
    input  logic        BitValid,
    output logic        BitReady,
    output logic [15:0] Dout,
    output logic        DoutValid,
    output logic        Epoch,
    output logic        Busy
);

    localparam int unsigned CW = (CHIP_DIV > 32'd1) ? $clog2(CHIP_DIV) : 32'd1;
    localparam int unsigned PW = (PRE_PER > 32'd1) ? $clog2(PRE_PER) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHIP_DIV - 32'd1);
    localparam logic [PW-1:0] PER_LAST = PW'(PRE_PER - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    function automatic logic [PN_DEG-1:0] lfsr_step(input logic [PN_DEG-1:0] v);
        return {^(v & PN_TAPS), v[PN_DEG-1:1]};
    endfunction

    // Negative chip is the 16-bit two's complement of the magnitude.
    function automatic logic [15:0] chip_value(input logic s);
        logic [15:0] r;
        if (s) begin
            r = ~AMPL + 16'h0001;
        end else begin
            r = AMPL;
        end
        return r;
    endfunction

    state_t            state_r, state_n_s;
    logic [PN_DEG-1:0] lfsr_r, lfsr_n_s, lfsr_adv_s;
    logic [CW-1:0]     cnt_r, cnt_n_s;
    logic [PW-1:0]     per_r, per_n_s;
    logic              d_r, d_n_s;
    logic              tick_s, per_end_s, last_pre_s, handoff_s, active_n_s;
    logic [15:0]       dout_r;
    logic              dout_valid_r, epoch_r, busy_r;

    // Chip tick, period-end detection and the handshake window.
    always_comb begin
        tick_s     = (cnt_r == CNT_LAST);
        lfsr_adv_s = lfsr_step(lfsr_r);
        per_end_s  = tick_s && (lfsr_adv_s == PN_SEED);
        last_pre_s = (per_r == PER_LAST);
        handoff_s  = per_end_s && ((state_r == ST_DATA) ||
                                   ((state_r == ST_PREAMBLE) && last_pre_s));
    end

    assign BitReady = En && handoff_s;

    // Next-state, LFSR, chip divider, preamble counter and held data bit.
    always_comb begin
        state_n_s = state_r;
        lfsr_n_s  = lfsr_r;
        cnt_n_s   = cnt_r;
        per_n_s   = per_r;
        d_n_s     = d_r;
        if (!En) begin
            state_n_s = ST_IDLE;
            lfsr_n_s  = PN_SEED;
            cnt_n_s   = {CW{1'b0}};
            per_n_s   = {PW{1'b0}};
            d_n_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    lfsr_n_s  = PN_SEED;
                    cnt_n_s   = {CW{1'b0}};
                    per_n_s   = {PW{1'b0}};
                    d_n_s     = 1'b0;
                    state_n_s = BitValid ? ST_PREAMBLE : ST_IDLE;
                end
                ST_PREAMBLE, ST_DATA: begin
                    cnt_n_s  = tick_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
                    lfsr_n_s = tick_s ? lfsr_adv_s : lfsr_r;
                    if (handoff_s) begin
                        if (BitValid) begin
                            state_n_s = ST_DATA;
                            d_n_s     = BitIn;
                        end else begin
                            state_n_s = ST_IDLE;
                            per_n_s   = {PW{1'b0}};
                            d_n_s     = 1'b0;
                        end
                    end else if (per_end_s) begin
                        per_n_s = per_r + PW'(1'b1);
                    end else begin
                        state_n_s = state_r;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    lfsr_n_s  = PN_SEED;
                    cnt_n_s   = {CW{1'b0}};
                    per_n_s   = {PW{1'b0}};
                    d_n_s     = 1'b0;
                end
            endcase
        end
        active_n_s = (state_n_s != ST_IDLE);
    end

    // State registers; outputs are registered from next-state values so Dout tracks lfsr_r.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= PN_SEED;
            cnt_r        <= {CW{1'b0}};
            per_r        <= {PW{1'b0}};
            d_r          <= 1'b0;
            dout_r       <= 16'h0000;
            dout_valid_r <= 1'b0;
            epoch_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            lfsr_r       <= lfsr_n_s;
            cnt_r        <= cnt_n_s;
            per_r        <= per_n_s;
            d_r          <= d_n_s;
            dout_r       <= active_n_s ? chip_value(lfsr_n_s[0] ^ d_n_s) : 16'h0000;
            dout_valid_r <= active_n_s;
            epoch_r      <= active_n_s && (lfsr_n_s == PN_SEED);
            busy_r       <= active_n_s;
        end
    end

    assign Dout      = dout_r;
    assign DoutValid = dout_valid_r;
    assign Epoch     = epoch_r;
    assign Busy      = busy_r;

endmodule
